// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the IF stage.
// Serves one-word fetches from a local array after a fixed number of wait states.
module instr_mem_responder #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [WORD_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_instruction
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [WORD_WIDTH-1:0] resp_q, resp_d;
  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]  req_idx;
  logic                  unused_addr_hi;

  // Upper PC bits are dropped, so fetches wrap modulo the array depth.
  assign req_idx        = req_addr[ADDR_BITS-1:0];
  assign unused_addr_hi = ^req_addr[WORD_WIDTH-1:ADDR_BITS];

  // Array has no reset and keeps loading even while rst is high.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_idx;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            resp_d  = mem[req_idx];
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_RESP;
            resp_d  = mem[addr_q];
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
    end
  end

  assign resp_valid       = (state_q == S_RESP) & ~flush;
  assign busy             = ~rst &
                            (((state_q == S_IDLE) & req_valid) |
                             (state_q == S_WAIT));
  assign resp_instruction = resp_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder.
// Instance u2 runs with two wait states, u0 with none; inputs are shared.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        busy2, rv2;
  logic [31:0] ri2;
  logic        busy0, rv0;
  logic [31:0] ri0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .WORD_WIDTH(32), .ADDR_BITS(8), .WAIT_CYCLES(2)
  ) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy2), .resp_valid(rv2),
    .resp_instruction(ri2)
  );

  instr_mem_responder #(
    .WORD_WIDTH(32), .ADDR_BITS(8), .WAIT_CYCLES(0)
  ) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .flush(flush), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy0), .resp_valid(rv0),
    .resp_instruction(ri0)
  );

  // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'd0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    tick();
    sample();
    total++;
    if ({busy2, rv2, busy0, rv0} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b expected 0000",
               {busy2, rv2, busy0, rv0});
    end else passed++;
    total++;
    if (ri2 !== 32'h0 || ri0 !== 32'h0) begin
      $display("FAIL reset_instr: got %h/%h expected 0/0", ri2, ri0);
    end else passed++;
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_w2();
    load(8'd5, 32'hE3A01001);
    req_valid = 1'b1;
    req_addr  = 32'd5;
    for (int k = 0; k < 4; k++) begin
      sample();
      total++;
      if (busy2 !== (k < 3) || rv2 !== (k == 3)) begin
        $display("FAIL w2_cycle%0d: got busy=%b rv=%b expected busy=%b rv=%b",
                 k, busy2, rv2, k < 3, k == 3);
      end else passed++;
      if (k == 3) begin
        total++;
        if (ri2 !== 32'hE3A01001) begin
          $display("FAIL w2_data: got %h expected e3a01001", ri2);
        end else passed++;
      end
      tick();
    end
    sample();
    total++;
    if (busy2 !== 1'b1 || rv2 !== 1'b0) begin
      $display("FAIL w2_back_idle: got busy=%b rv=%b expected busy=1 rv=0",
               busy2, rv2);
    end else passed++;
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_w0();
    logic [31:0] exp_d;
    load(8'd7, 32'h12345678);
    load(8'd8, 32'h0BADF00D);
    req_valid = 1'b1;
    req_addr  = 32'd7;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req_addr = 32'd8;
      sample();
      total++;
      if (busy0 !== (k % 2 == 0) || rv0 !== (k % 2 == 1)) begin
        $display("FAIL w0_cycle%0d: got busy=%b rv=%b expected busy=%b rv=%b",
                 k, busy0, rv0, k % 2 == 0, k % 2 == 1);
      end else passed++;
      if (k % 2 == 1) begin
        exp_d = (k == 1) ? 32'h12345678 : 32'h0BADF00D;
        total++;
        if (ri0 !== exp_d) begin
          $display("FAIL w0_data%0d: got %h expected %h", k, ri0, exp_d);
        end else passed++;
      end
      if (k == 3) req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_flush_wait();
    load(8'd3, 32'h33333333);
    load(8'd9, 32'h99999999);
    req_valid = 1'b1;
    req_addr  = 32'd3;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    sample();
    total++;
    if (busy2 !== 1'b1 || rv2 !== 1'b0) begin
      $display("FAIL flush_wait: got busy=%b rv=%b expected busy=1 rv=0",
               busy2, rv2);
    end else passed++;
    tick();
    flush     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd9;
    sample();
    total++;
    if (rv2 !== 1'b0 || ri2 !== 32'h12345678) begin
      $display("FAIL flush_hold: got rv=%b data=%h expected rv=0 data=12345678",
               rv2, ri2);
    end else passed++;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) req_valid = 1'b0;
      if (k > 0) begin
        sample();
        total++;
        if (busy2 !== (k < 3) || rv2 !== (k == 3)) begin
          $display("FAIL refetch_cycle%0d: got busy=%b rv=%b expected busy=%b rv=%b",
                   k, busy2, rv2, k < 3, k == 3);
        end else passed++;
      end
      tick();
    end
    total++;
    if (ri2 !== 32'h99999999) begin
      $display("FAIL refetch_data: got %h expected 99999999", ri2);
    end else passed++;
  endtask

  task automatic test_flush_resp();
    req_valid = 1'b1;
    req_addr  = 32'd7;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    sample();
    total++;
    if (rv0 !== 1'b0) begin
      $display("FAIL flush_resp: got rv=%b expected 0", rv0);
    end else passed++;
    tick();
    flush     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'd8;
    sample();
    total++;
    if (busy0 !== 1'b1 || rv0 !== 1'b0) begin
      $display("FAIL flush_resp_idle: got busy=%b rv=%b expected busy=1 rv=0",
               busy0, rv0);
    end else passed++;
    tick();
    req_valid = 1'b0;
    sample();
    total++;
    if (rv0 !== 1'b1 || ri0 !== 32'h0BADF00D) begin
      $display("FAIL flush_resp_next: got rv=%b data=%h expected rv=1 data=0badf00d",
               rv0, ri0);
    end else passed++;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_rst_mid();
    req_valid = 1'b1;
    req_addr  = 32'd5;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    sample();
    total++;
    if (busy2 !== 1'b0 || rv2 !== 1'b0 || ri2 !== 32'h0) begin
      $display("FAIL rst_mid: got busy=%b rv=%b data=%h expected 0 0 0",
               busy2, rv2, ri2);
    end else passed++;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      total++;
      if (rv2 !== 1'b0 || busy2 !== 1'b0) begin
        $display("FAIL rst_lost%0d: got busy=%b rv=%b expected 0 0",
                 k, busy2, rv2);
      end else passed++;
      tick();
    end
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    sample();
    total++;
    if (rv2 !== 1'b1 || ri2 !== 32'hE3A01001) begin
      $display("FAIL rst_refetch: got rv=%b data=%h expected rv=1 data=e3a01001",
               rv2, ri2);
    end else passed++;
    tick();
  endtask

  task automatic test_wrap_and_rw();
    load(8'd0, 32'hAAAA5555);
    load(8'd4, 32'h44444444);
    req_valid = 1'b1;
    req_addr  = 32'h100;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    sample();
    total++;
    if (rv2 !== 1'b1 || ri2 !== 32'hAAAA5555) begin
      $display("FAIL wrap: got rv=%b data=%h expected rv=1 data=aaaa5555",
               rv2, ri2);
    end else passed++;
    tick();
    req_valid = 1'b1;
    req_addr  = 32'd4;
    tick();
    req_valid = 1'b0;
    tick();
    load_en   = 1'b1;
    load_addr = 8'd4;
    load_data = 32'h4A4A4A4A;
    tick();
    load_en = 1'b0;
    sample();
    total++;
    if (rv2 !== 1'b1 || ri2 !== 32'h44444444) begin
      $display("FAIL rw_old: got rv=%b data=%h expected rv=1 data=44444444",
               rv2, ri2);
    end else passed++;
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    sample();
    total++;
    if (rv2 !== 1'b1 || ri2 !== 32'h4A4A4A4A) begin
      $display("FAIL rw_new: got rv=%b data=%h expected rv=1 data=4a4a4a4a",
               rv2, ri2);
    end else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_w2();
    test_back_to_back_w0();
    test_flush_wait();
    test_flush_resp();
    test_rst_mid();
    test_wrap_and_rw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
